// File: rtl/cache_mem_responder_pkg.sv
// Shared message layouts and constants for the cache memory port.
// The request/response structs mirror the 4-byte memory messages used across the cache benches.
package cache_mem_pkg;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

  localparam int REQ_W           = 77;
  localparam int REQ_TYPE_LSB    = 74;
  localparam int REQ_OPAQUE_LSB  = 66;
  localparam int REQ_ADDR_LSB    = 34;
  localparam int REQ_LEN_LSB     = 32;
  localparam int REQ_DATA_LSB    = 0;

  localparam int RESP_W          = 47;
  localparam int RESP_TYPE_LSB   = 44;
  localparam int RESP_OPAQUE_LSB = 36;
  localparam int RESP_TEST_LSB   = 34;
  localparam int RESP_LEN_LSB    = 32;
  localparam int RESP_DATA_LSB   = 0;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_e;

  // len = 0 means a full word; otherwise the low len bytes.
  function automatic logic [31:0] len_mask(input logic [1:0] len);
    case (len)
      2'd1:    len_mask = 32'h0000_00ff;
      2'd2:    len_mask = 32'h0000_ffff;
      2'd3:    len_mask = 32'h00ff_ffff;
      default: len_mask = 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_responder_resp_queue.sv
// In-order response queue: each slot holds a response and a latency timer,
// and the head is released only once its timer has expired.
module cache_mem_resp_queue
  import cache_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_val,
  input  mem_resp_4B_t             enq_msg,
  input  logic                     deq_rdy,
  output logic                     deq_val,
  output mem_resp_4B_t             deq_msg,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [TW-1:0] TIMER_INIT = TW'(LAT - 1);
  localparam slot_state_e   LOAD_STATE = (LAT == 1) ? SLOT_READY : SLOT_WAIT;

  slot_state_e   state_q [DEPTH];
  slot_state_e   state_d [DEPTH];
  logic [TW-1:0] timer_q [DEPTH];
  logic [TW-1:0] timer_d [DEPTH];
  mem_resp_4B_t  msg_q   [DEPTH];
  mem_resp_4B_t  msg_d   [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          deq;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    msg_d   = msg_q;
    head_d  = head_q;
    tail_d  = tail_q;

    deq_val = (count_q != '0) && (state_q[head_q] == SLOT_READY);
    deq     = deq_val && deq_rdy;

    // Timers run regardless of the head, so a stalled queue drains back-to-back.
    for (int i = 0; i < DEPTH; i++) begin
      if (state_q[i] == SLOT_WAIT) begin
        timer_d[i] = timer_q[i] - 1'b1;
        if (timer_q[i] == TW'(1)) state_d[i] = SLOT_READY;
      end
    end

    if (deq) begin
      state_d[head_q] = SLOT_EMPTY;
      head_d          = head_q + 1'b1;
    end

    // The tail slot is always empty when enq_val is offered (top never enqueues at full).
    if (enq_val) begin
      state_d[tail_q] = LOAD_STATE;
      timer_d[tail_q] = TIMER_INIT;
      msg_d[tail_q]   = enq_msg;
      tail_d          = tail_q + 1'b1;
    end

    count_d = count_q + CW'(enq_val) - CW'(deq);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= SLOT_EMPTY;
        timer_q[i] <= '0;
        msg_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      timer_q <= timer_d;
      msg_q   <= msg_d;
    end
  end

  assign deq_msg = msg_q[head_q];
  assign count   = count_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Word-level memory responder: byte-masked storage plus a fixed-latency,
// in-order response queue with bounded buffering.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LAT       = 2,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memreq_val,
  output logic                       memreq_rdy,
  input  logic [REQ_W-1:0]           memreq_msg,
  output logic                       memresp_val,
  input  logic                       memresp_rdy,
  output logic [RESP_W-1:0]          memresp_msg,
  output logic [$clog2(DEPTH):0]     num_outstanding
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   mem_q [NUM_WORDS];
  mem_req_4B_t   req;
  mem_resp_4B_t  resp_d;
  mem_resp_4B_t  resp_out;
  logic [IW-1:0] idx;
  logic [31:0]   mask;
  logic [31:0]   rd_word;
  logic [31:0]   wr_data;
  logic          accept;
  logic          wr_en;
  logic [CW-1:0] count;
  logic          unused_addr_bits;

  // Ready depends only on reset and occupancy, never on memresp_rdy.
  assign memreq_rdy = !reset && (count < CW'(DEPTH));

  always_comb begin
    req     = mem_req_4B_t'(memreq_msg);
    idx     = req.addr[IW+1:2];
    accept  = memreq_val && memreq_rdy;
    mask    = len_mask(req.len);
    rd_word = mem_q[idx];
    wr_en   = accept && ((req.type_ == MEM_WRITE) || (req.type_ == MEM_INIT));
    wr_data = (rd_word & ~mask) | (req.data & mask);

    resp_d        = '0;
    resp_d.type_  = req.type_;
    resp_d.opaque = req.opaque;
    resp_d.len    = req.len;
    if (req.type_ == MEM_READ) resp_d.data = rd_word & mask;
  end

  assign unused_addr_bits = ^{req.addr[31:IW+2], req.addr[1:0]};

  // NOTE: the storage array has no reset; benches preload it with INIT requests.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wr_data;
  end

  cache_mem_resp_queue #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) u_resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (accept),
    .enq_msg (resp_d),
    .deq_rdy (memresp_rdy),
    .deq_val (memresp_val),
    .deq_msg (resp_out),
    .count   (count)
  );

  assign memresp_msg     = resp_out;
  assign num_outstanding = count;

endmodule
